// File: rtl/logic_unit_serial.sv
// rtl/logic_unit_serial.sv - multi-cycle bitwise logic unit, SLICE bits per clock LSB first
module logic_unit_serial #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_next;
  logic [2:0]       op_sh;
  logic [SLICE-1:0] sa, sb, sr;
  logic             accept, last;
  int               base;

  assign accept = start && (state != BUSY);
  assign last   = (cnt == CW'(N - 1));

  always_comb begin
    base = int'(cnt) * SLICE;
    sa   = a_sh[base +: SLICE];
    sb   = b_sh[base +: SLICE];
    case (op_sh)
      3'b000:  sr = sa & sb;
      3'b001:  sr = sa | sb;
      3'b010:  sr = sa ^ sb;
      3'b011:  sr = ~(sa & sb);
      3'b100:  sr = ~(sa | sb);
      3'b101:  sr = ~(sa ^ sb);
      3'b110:  sr = sa & ~sb;
      default: sr = ~sa;
    endcase
    acc_next              = acc;
    acc_next[base +: SLICE] = sr;
  end

  // result/flags load from acc_next so the final slice lands in the same edge as done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      op_sh  <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      parity <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state <= BUSY;
        busy  <= 1'b1;
        cnt   <= '0;
        acc   <= '0;
        a_sh  <= a;
        b_sh  <= b;
        op_sh <= op;
      end else if (state == BUSY) begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
        if (last) begin
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= acc_next;
          zero   <= ~|acc_next;
          parity <= ^acc_next;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_serial.sv
// tb/tb_logic_unit_serial.sv - directed-vector bench for logic_unit_serial
module tb_logic_unit_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, zero, parity;
  logic [31:0] result;

  logic        start8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, zero8, parity8;
  logic [7:0]  result8;

  int n_vec = 0;
  int n_bad = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  logic_unit_serial #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .parity(parity)
  );

  logic_unit_serial #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .zero(zero8), .parity(parity8)
  );

  always @(negedge clk) if ((busy && done) || (busy8 && done8)) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lat = cycles until done is seen (0 = timed out), nbusy = busy samples before it
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_r,
                        input logic exp_z, input logic exp_p);
    int lat, nb;
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_at_start"}, busy, 1);
    wait_done(lat, nb);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_busy_cycles"}, nb + 1, 4);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_zero"}, zero, exp_z);
    check({tag, "_parity"}, parity, exp_p);
    step();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int lat, nb, ndone, cyc, idx;
    logic [31:0] exp_seq [3];
    int exp_cyc [3];

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 32'h0);
    check("rst_zero", zero, 1);
    check("rst_parity", parity, 0);
    check("rst8_result", result8, 8'h0);
    step();
    rst_n = 1'b1;

    run_op("xor1", 3'b010, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1);
    run_op("xor_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    run_op("nor0", 3'b100, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("nota", 3'b111, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000, 1'b0, 1'b0);

    // input changes and a second start during BUSY must be ignored
    op = 3'b000; a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; start = 1'b1;
    step();
    a = 32'h0; b = 32'h0; op = 3'b001;
    step();
    start = 1'b0;
    check("shadow_busy", busy, 1);
    check("shadow_hold_result", result, 32'hFFFF_0000);
    wait_done(lat, nb);
    check("shadow_latency", lat + 1, 4);
    check("shadow_result", result, 32'hF000_F000);
    ndone = 0;
    repeat (6) begin
      step();
      if (done) ndone++;
    end
    check("shadow_single_done", ndone, 0);

    // back-to-back with start held high, alternating XOR / XNOR
    exp_seq[0] = 32'h1D3B_5977; exp_seq[1] = 32'hE2C4_A688; exp_seq[2] = 32'h1D3B_5977;
    exp_cyc[0] = 4; exp_cyc[1] = 9; exp_cyc[2] = 14;
    op = 3'b010; a = 32'h1234_5678; b = 32'h0F0F_0F0F; start = 1'b1;
    step();
    idx = 0;
    for (cyc = 1; cyc <= 30 && idx < 3; cyc++) begin
      step();
      if (done) begin
        check($sformatf("b2b_cycle%0d", idx), cyc, exp_cyc[idx]);
        check($sformatf("b2b_result%0d", idx), result, exp_seq[idx]);
        op = (op == 3'b010) ? 3'b101 : 3'b010;
        idx++;
      end
    end
    check("b2b_count", idx, 3);
    start = 1'b0;
    step();
    step();
    check("b2b_idle", busy, 0);

    // asynchronous reset mid-operation
    op = 3'b010; a = 32'h3; b = 32'h1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 32'h0);
    check("abort_zero", zero, 1);
    step();
    rst_n = 1'b1;
    ndone = 0;
    repeat (6) begin
      step();
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op("post_rst", 3'b010, 32'h3, 32'h1, 32'h2, 1'b0, 1'b1);

    // single-slice instance
    op8 = 3'b110; a8 = 8'hAA; b8 = 8'h0F; start8 = 1'b1;
    step();
    start8 = 1'b0;
    check("w8_busy", busy8, 1);
    step();
    check("w8_done", done8, 1);
    check("w8_result", result8, 8'hA0);
    check("w8_parity", parity8, 0);
    check("w8_zero", zero8, 0);
    step();
    check("w8_done_pulse", done8, 0);

    check("busy_done_overlap", overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
